// File: rtl/ovl_sem_pkg.sv
// Shared types and constants for the OVL semantic-harness time-family sequencer.
package ovl_sem_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    START = 3'd2,
    WIN   = 3'd3,
    GAP   = 3'd4,
    CHECK = 3'd5
  } sched_state_e;

  localparam int OVL_FIRE_2STATE = 0;
  localparam int FIRE_CNT_W      = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ovl_sem_phase_cnt.sv
// Loadable down-counter shared by the LEAD, WIN and GAP phases; parks at zero.
module ovl_sem_phase_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         zero
);

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/ovl_sem_time_sched.sv
// Stimulus/response sequencer for an ovl_time checker: issues start events,
// drives test_expr over each window, counts checker fires and gives a verdict.
module ovl_sem_time_sched
  import ovl_sem_pkg::*;
#(
  parameter int  NUM_CKS    = 2,
  parameter int  NUM_EVENTS = 3,
  parameter int  LEAD_CKS   = 1,
  parameter int  GAP_CKS    = 2,
  parameter int  FAIL_IDX   = 1,
  localparam int EW         = $clog2(NUM_EVENTS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  inject_fail,
  input  logic [2:0]            fire,
  output logic                  ovl_enable,
  output logic                  start_event,
  output logic                  test_expr,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [EW-1:0]         event_idx,
  output logic [FIRE_CNT_W-1:0] fire_count,
  output sched_state_e          dbg_state
);

  // Handshake: go is a level sampled only in IDLE; done is a one-cycle pulse,
  // pass is valid alongside it and held until the next accepted go.

  localparam int PW = $clog2(max3(LEAD_CKS, NUM_CKS, GAP_CKS) + 1);
  localparam logic [PW-1:0] LEAD_LD  = PW'((LEAD_CKS > 0) ? LEAD_CKS - 1 : 0);
  localparam logic [PW-1:0] WIN_LD   = PW'(NUM_CKS - 1);
  localparam logic [PW-1:0] GAP_LD   = PW'(GAP_CKS - 1);
  localparam logic [EW-1:0] LAST_IDX = EW'(NUM_EVENTS - 1);
  localparam logic [EW-1:0] FAIL_I   = EW'(FAIL_IDX);

  if (NUM_CKS < 1 || NUM_EVENTS < 1 || LEAD_CKS < 0 || GAP_CKS < 1 ||
      FAIL_IDX < 0 || FAIL_IDX >= NUM_EVENTS) begin : g_bad_params
    $error("ovl_sem_time_sched: illegal parameter combination");
  end

  sched_state_e state, state_next;
  logic                  inj, inj_next;
  logic [EW-1:0]         idx, idx_next;
  logic [FIRE_CNT_W-1:0] fc_next;
  logic                  pass_next;
  logic                  ph_load;
  logic [PW-1:0]         ph_load_val;
  logic [PW-1:0]         ph_value;
  logic                  ph_zero;
  logic                  busy_next, start_next, expr_next, done_next;
  logic                  unused_fire;

  assign unused_fire = ^{fire[2:1], ph_value};

  ovl_sem_phase_cnt #(.W(PW)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (ph_load),
    .load_val (ph_load_val),
    .value    (ph_value),
    .zero     (ph_zero)
  );

  always_comb begin
    state_next  = state;
    inj_next    = inj;
    idx_next    = idx;
    ph_load     = 1'b0;
    ph_load_val = '0;
    case (state)
      IDLE: begin
        if (go) begin
          inj_next = inject_fail;
          idx_next = '0;
          if (LEAD_CKS > 0) begin
            state_next  = LEAD;
            ph_load     = 1'b1;
            ph_load_val = LEAD_LD;
          end else begin
            state_next = START;
          end
        end
      end
      LEAD:  if (ph_zero) state_next = START;
      START: begin
        state_next  = WIN;
        ph_load     = 1'b1;
        ph_load_val = WIN_LD;
      end
      WIN: begin
        if (ph_zero) begin
          state_next  = GAP;
          ph_load     = 1'b1;
          ph_load_val = GAP_LD;
        end
      end
      GAP: begin
        if (ph_zero) begin
          if (idx == LAST_IDX) begin
            state_next = CHECK;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = START;
          end
        end
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fire counting and verdict; CHECK sees the count as it stood entering CHECK.
  always_comb begin
    fc_next   = fire_count;
    pass_next = pass;
    if (state == IDLE) begin
      if (go) begin
        fc_next   = '0;
        pass_next = 1'b0;
      end
    end else if (fire[OVL_FIRE_2STATE] && (fire_count != '1)) begin
      fc_next = fire_count + 1'b1;
    end
    if (state_next == CHECK) begin
      pass_next = inj_next ? (fc_next != '0) : (fc_next == '0);
    end
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    busy_next  = (state_next != IDLE);
    start_next = (state_next == START);
    done_next  = (state_next == CHECK);
    case (state_next)
      IDLE:    expr_next = 1'b0;
      WIN:     expr_next = !(inj_next && (idx_next == FAIL_I));
      default: expr_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      inj         <= 1'b0;
      idx         <= '0;
      fire_count  <= '0;
      pass        <= 1'b0;
      busy        <= 1'b0;
      ovl_enable  <= 1'b0;
      start_event <= 1'b0;
      test_expr   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      inj         <= inj_next;
      idx         <= idx_next;
      fire_count  <= fc_next;
      pass        <= pass_next;
      busy        <= busy_next;
      ovl_enable  <= busy_next;
      start_event <= start_next;
      test_expr   <= expr_next;
      done        <= done_next;
    end
  end

  assign event_idx = idx;
  assign dbg_state = state;

endmodule
